// File: rtl/uart_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int IMEM_WORD_BYTES = 4;

endpackage

// File: rtl/uart_imem_programmer_if.sv
// Write port from the boot loader into instruction memory / fetch stage.
interface uart_imem_programmer_if;

  logic [31:0] uart_dout;
  logic [31:0] imem_addr;
  logic        imem_wea;
  logic        memcon_prog_ena;

  modport master (
    output uart_dout,
    output imem_addr,
    output imem_wea,
    output memcon_prog_ena
  );

  modport slave (
    input uart_dout,
    input imem_addr,
    input imem_wea,
    input memcon_prog_ena
  );

endinterface

// File: rtl/uart_imem_programmer_rx.sv
// 8N1 UART receiver: synchronizer, bit timer, FSM and shift register.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q;
  rx_state_t     state_d;
  logic          rx_m;
  logic          rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          half_done;
  logic          full_done;

  assign half_done = (timer == HALF_LAST);
  assign full_done = (timer == FULL_LAST);
  assign byte_data = shreg;

  // Flops reset to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (half_done) state_d = rx_s ? IDLE : DATA;
      DATA:  if (full_done && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (full_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
        end
        START: begin
          timer <= half_done ? '0 : timer + TW'(1);
        end
        DATA: begin
          if (full_done) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (full_done) begin
            timer      <= '0;
            byte_valid <= rx_s;
            frame_err  <= ~rx_s;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_programmer.sv
// Boot loader top: packs UART bytes into words and writes them to imem.
module uart_imem_programmer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   prog,
  input  logic                   rx,
  uart_imem_programmer_if.master imem,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       word_count
);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        fe_pulse;
  logic        ena;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [31:0] dout_q;
  logic [31:0] addr_q;
  logic        wea_q;
  logic        session_start;
  logic        last_byte;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .Rst       (Rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (fe_pulse)
  );

  assign session_start = prog & ~ena;
  assign last_byte     = (byte_idx == 2'(IMEM_WORD_BYTES - 1));

  assign imem.uart_dout       = dout_q;
  assign imem.imem_addr       = addr_q;
  assign imem.imem_wea        = wea_q;
  assign imem.memcon_prog_ena = ena;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ena        <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      ena <= prog;
      if (session_start) begin
        frame_err  <= 1'b0;
        word_count <= '0;
      end else begin
        if (fe_pulse) frame_err <= 1'b1;
        if (wea_q)    word_count <= word_count + CNT_W'(1);
      end
    end
  end

  // Write is gated by live prog so a drop on the last byte suppresses it.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      byte_idx <= '0;
      word_buf <= '0;
      dout_q   <= '0;
      addr_q   <= '0;
      wea_q    <= 1'b0;
    end else if (!ena) begin
      byte_idx <= '0;
      addr_q   <= '0;
      wea_q    <= 1'b0;
    end else begin
      wea_q <= 1'b0;
      if (wea_q) addr_q <= addr_q + 32'd4;
      if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: word_buf[7:0]   <= byte_data;
          2'd1: word_buf[15:8]  <= byte_data;
          2'd2: word_buf[23:16] <= byte_data;
          default: ;
        endcase
        if (last_byte && prog) begin
          dout_q <= {byte_data, word_buf};
          wea_q  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_programmer.sv
// Directed bench for the UART boot loader at 16 clocks per bit.
module tb_uart_imem_programmer;

  localparam int CPB   = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             Rst = 1'b0;
  logic             prog = 1'b0;
  logic             rx = 1'b1;
  logic             frame_err;
  logic [CNT_W-1:0] word_count;

  uart_imem_programmer_if imem ();

  uart_imem_programmer #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .prog      (prog),
    .rx        (rx),
    .imem      (imem.master),
    .frame_err (frame_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int bv_cnt = 0;
  int wide_err = 0;
  logic prev_wea = 1'b0;
  logic [31:0] wr_d [0:63];
  logic [31:0] wr_a [0:63];

  always @(negedge clk) begin
    if (imem.imem_wea) begin
      if (wr_cnt < 64) begin
        wr_d[wr_cnt] = imem.uart_dout;
        wr_a[wr_cnt] = imem.imem_addr;
      end
      wr_cnt++;
      if (prev_wea) wide_err++;
    end
    prev_wea = imem.imem_wea;
    if (dut.u_rx.byte_valid) bv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    if (bad_stop) begin
      rx = 1'b0;
      wait_clks(12);
      rx = 1'b1;
      wait_clks(4);
    end else begin
      rx = 1'b1;
      wait_clks(CPB);
    end
    wait_clks(CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0], 1'b0);
    end
  endtask

  int base;
  int bv0;

  initial begin
    #23;
    chk("rst_dout", imem.uart_dout, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_wea", {31'h0, imem.imem_wea}, 32'h0);
    chk("rst_ena", {31'h0, imem.memcon_prog_ena}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_wc", 32'(word_count), 32'h0);
    Rst = 1'b1;
    wait_clks(3);

    // word assembly and address increment
    prog = 1'b1;
    wait_clks(3);
    chk("ena_on", {31'h0, imem.memcon_prog_ena}, 32'h1);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    chk("asm_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("asm_d0", wr_d[0], 32'h0000_0013);
    chk("asm_a0", wr_a[0], 32'h0);
    chk("asm_d1", wr_d[1], 32'hDEAD_BEEF);
    chk("asm_a1", wr_a[1], 32'h4);
    chk("asm_wc", 32'(word_count), 32'd2);
    chk("asm_addr", imem.imem_addr, 32'h8);
    chk("asm_dout_hold", imem.uart_dout, 32'hDEAD_BEEF);

    // glitch rejection
    bv0 = bv_cnt;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(3 * CPB);
    chk("gl_bv", 32'(bv_cnt), 32'(bv0));
    chk("gl_idx", 32'(dut.byte_idx), 32'h0);
    chk("gl_ferr", {31'h0, frame_err}, 32'h0);

    // framing error then a good word
    bv0 = bv_cnt;
    send_byte(8'h55, 1'b1);
    chk("fe_ferr", {31'h0, frame_err}, 32'h1);
    chk("fe_bv", 32'(bv_cnt), 32'(bv0));
    chk("fe_idx", 32'(dut.byte_idx), 32'h0);
    base = wr_cnt;
    send_word(32'h4433_2211);
    chk("fe_wr_cnt", 32'(wr_cnt - base), 32'd1);
    chk("fe_d", wr_d[base], 32'h4433_2211);
    chk("fe_a", wr_a[base], 32'h8);
    chk("fe_wc", 32'(word_count), 32'd3);

    // session restart
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    prog = 1'b0;
    wait_clks(5);
    prog = 1'b1;
    wait_clks(5);
    chk("rs_ferr", {31'h0, frame_err}, 32'h0);
    chk("rs_idx", 32'(dut.byte_idx), 32'h0);
    base = wr_cnt;
    send_word(32'h0403_0201);
    chk("rs_wr_cnt", 32'(wr_cnt - base), 32'd1);
    chk("rs_d", wr_d[base], 32'h0403_0201);
    chk("rs_a", wr_a[base], 32'h0);
    chk("rs_wc", 32'(word_count), 32'd1);

    // bytes outside a session
    prog = 1'b0;
    wait_clks(3);
    base = wr_cnt;
    send_word(32'hCAFE_F00D);
    chk("off_wr_cnt", 32'(wr_cnt - base), 32'd0);
    chk("off_ena", {31'h0, imem.memcon_prog_ena}, 32'h0);
    chk("off_addr", imem.imem_addr, 32'h0);

    // reset in the middle of the third byte
    prog = 1'b1;
    wait_clks(3);
    send_word(32'h4030_2010);
    chk("rm_pre_wc", 32'(word_count), 32'd1);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    rx = 1'b0;
    wait_clks(4 * CPB);
    #3;
    Rst = 1'b0;
    #1;
    chk("rm_dout", imem.uart_dout, 32'h0);
    chk("rm_addr", imem.imem_addr, 32'h0);
    chk("rm_wea", {31'h0, imem.imem_wea}, 32'h0);
    chk("rm_ena", {31'h0, imem.memcon_prog_ena}, 32'h0);
    chk("rm_ferr", {31'h0, frame_err}, 32'h0);
    chk("rm_wc", 32'(word_count), 32'h0);
    rx = 1'b1;
    wait_clks(3);
    Rst = 1'b1;
    wait_clks(4);
    base = wr_cnt;
    send_word(32'h1234_5678);
    chk("rm_wr_cnt", 32'(wr_cnt - base), 32'd1);
    chk("rm_d", wr_d[base], 32'h1234_5678);
    chk("rm_a", wr_a[base], 32'h0);
    chk("rm_post_wc", 32'(word_count), 32'd1);

    chk("wea_width", 32'(wide_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
